// File: rtl/phase_accum_pkg.sv
// Shared types for the phase accumulator: the source selector used by the
// phase register's next-value mux.
package phase_accum_pkg;

  typedef enum logic [1:0] {
    PHASE_HOLD    = 2'd0,
    PHASE_LOAD    = 2'd1,
    PHASE_ADVANCE = 2'd2
  } phase_src_e;

endpackage

// File: rtl/phase_accum.sv
// Free-running phase accumulator (NCO front end) with AXI-Stream style ports.
// Each accepted output beat advances the phase by a programmable step. The
// phase can be overwritten (load/sync), and the step is reprogrammable.
module phase_accum
  import phase_accum_pkg::*;
#(
  parameter int                WIDTH              = 32,
  parameter logic [WIDTH-1:0]  INITIAL_PHASE      = '0,
  parameter logic [WIDTH-1:0]  INITIAL_PHASE_STEP = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] input_phase_tdata,
  input  logic             input_phase_tvalid,
  output logic             input_phase_tready,
  input  logic [WIDTH-1:0] input_phase_step_tdata,
  input  logic             input_phase_step_tvalid,
  output logic             input_phase_step_tready,
  output logic [WIDTH-1:0] output_phase_tdata,
  output logic             output_phase_tvalid,
  input  logic             output_phase_tready
);

  logic [WIDTH-1:0] phase_reg;
  logic [WIDTH-1:0] step_reg;
  logic [WIDTH-1:0] phase_next;
  phase_src_e       phase_src;

  // A load is only taken when downstream is consuming, so backpressure
  // blocks loads as well as advances. Steps are never refused.
  assign input_phase_tready      = output_phase_tready;
  assign input_phase_step_tready = 1'b1;
  assign output_phase_tvalid     = 1'b1;
  assign output_phase_tdata      = phase_reg;

  // Pick where the next phase comes from: a load beats an advance.
  always_comb begin
    phase_src = PHASE_HOLD;
    if (input_phase_tvalid && input_phase_tready) begin
      phase_src = PHASE_LOAD;
    end else if (output_phase_tready) begin
      phase_src = PHASE_ADVANCE;
    end
  end

  // Next-phase mux; the advance wraps modulo 2^WIDTH with the carry dropped.
  always_comb begin
    phase_next = phase_reg;
    case (phase_src)
      PHASE_LOAD:    phase_next = input_phase_tdata;
      PHASE_ADVANCE: phase_next = phase_reg + step_reg;
      default:       phase_next = phase_reg;
    endcase
  end

  // Phase and step registers; reset overrides any load, advance or step write.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_reg <= INITIAL_PHASE;
      step_reg  <= INITIAL_PHASE_STEP;
    end else begin
      phase_reg <= phase_next;
      if (input_phase_step_tvalid) begin
        step_reg <= input_phase_step_tdata;
      end
    end
  end

endmodule

// File: tb/tb_phase_accum.sv
// Directed bench for phase_accum: two instances, one with zero initial values
// and one with INITIAL_PHASE=0x1000 / INITIAL_PHASE_STEP=0x10 for the
// mid-stream reset case. Expected values are hand-computed constants.
module tb_phase_accum;

  logic        clk;
  int          assertCount;
  int          failCount;

  // Instance A: default initial values
  logic        rst_a;
  logic [31:0] load_data_a;
  logic        load_valid_a;
  logic        load_ready_a;
  logic [31:0] step_data_a;
  logic        step_valid_a;
  logic        step_ready_a;
  logic [31:0] out_data_a;
  logic        out_valid_a;
  logic        out_ready_a;

  // Instance B: nonzero initial values
  logic        rst_b;
  logic [31:0] load_data_b;
  logic        load_valid_b;
  logic        load_ready_b;
  logic [31:0] step_data_b;
  logic        step_valid_b;
  logic        step_ready_b;
  logic [31:0] out_data_b;
  logic        out_valid_b;
  logic        out_ready_b;

  phase_accum #(
    .WIDTH(32),
    .INITIAL_PHASE(32'h0),
    .INITIAL_PHASE_STEP(32'h0)
  ) dut_a (
    .clk(clk),
    .rst(rst_a),
    .input_phase_tdata(load_data_a),
    .input_phase_tvalid(load_valid_a),
    .input_phase_tready(load_ready_a),
    .input_phase_step_tdata(step_data_a),
    .input_phase_step_tvalid(step_valid_a),
    .input_phase_step_tready(step_ready_a),
    .output_phase_tdata(out_data_a),
    .output_phase_tvalid(out_valid_a),
    .output_phase_tready(out_ready_a)
  );

  phase_accum #(
    .WIDTH(32),
    .INITIAL_PHASE(32'h0000_1000),
    .INITIAL_PHASE_STEP(32'h0000_0010)
  ) dut_b (
    .clk(clk),
    .rst(rst_b),
    .input_phase_tdata(load_data_b),
    .input_phase_tvalid(load_valid_b),
    .input_phase_tready(load_ready_b),
    .input_phase_step_tdata(step_data_b),
    .input_phase_step_tvalid(step_valid_b),
    .input_phase_step_tready(step_ready_b),
    .output_phase_tdata(out_data_b),
    .output_phase_tvalid(out_valid_b),
    .output_phase_tready(out_ready_b)
  );

  // 10-unit clock period
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Count one comparison and report it if the observed value is wrong
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    end
  endtask

  // Advance one clock edge, then check instance A's phase output
  task automatic applyStimulus(input string tag, input logic [31:0] expected);
    @(posedge clk);
    #1;
    checkOutput(tag, out_data_a, expected);
  endtask

  // Advance one clock edge, then check instance B's phase output
  task automatic applyStimulusB(input string tag, input logic [31:0] expected);
    @(posedge clk);
    #1;
    checkOutput(tag, out_data_b, expected);
  endtask

  initial begin
    assertCount  = 0;
    failCount    = 0;

    rst_a        = 1'b1;
    load_data_a  = 32'h0;
    load_valid_a = 1'b0;
    step_data_a  = 32'h0;
    step_valid_a = 1'b0;
    out_ready_a  = 1'b0;

    rst_b        = 1'b1;
    load_data_b  = 32'h0;
    load_valid_b = 1'b0;
    step_data_b  = 32'h0;
    step_valid_b = 1'b0;
    out_ready_b  = 1'b0;

    $display("[TB] phase_accum directed test starting");

    // Reset state of instance A
    applyStimulus("reset_phase", 32'h0);
    checkOutput("reset_tvalid", {31'b0, out_valid_a}, 32'h1);
    checkOutput("reset_step_tready", {31'b0, step_ready_a}, 32'h1);
    checkOutput("reset_tready_low", {31'b0, load_ready_a}, 32'h0);
    out_ready_a = 1'b1;
    #1;
    checkOutput("reset_tready_high", {31'b0, load_ready_a}, 32'h1);
    checkOutput("reset_b_phase", out_data_b, 32'h0000_1000);

    // Step program: 0x100, first used one edge later
    rst_a        = 1'b0;
    step_data_a  = 32'h0000_0100;
    step_valid_a = 1'b1;
    applyStimulus("step_0", 32'h0);
    step_valid_a = 1'b0;
    applyStimulus("step_1", 32'h0000_0100);
    applyStimulus("step_2", 32'h0000_0200);
    applyStimulus("step_3", 32'h0000_0300);

    // Wrap around 2^32
    load_data_a  = 32'hFFFF_FF00;
    load_valid_a = 1'b1;
    applyStimulus("wrap_load", 32'hFFFF_FF00);
    load_valid_a = 1'b0;
    applyStimulus("wrap_0", 32'h0000_0000);
    applyStimulus("wrap_1", 32'h0000_0100);

    // Phase load with downstream ready
    load_data_a  = 32'h1234_5678;
    load_valid_a = 1'b1;
    applyStimulus("load_val", 32'h1234_5678);
    load_valid_a = 1'b0;
    applyStimulus("load_adv", 32'h1234_5778);

    // Backpressure: phase frozen, load refused, step change accepted
    out_ready_a  = 1'b0;
    load_data_a  = 32'hDEAD_BEEF;
    load_valid_a = 1'b1;
    step_data_a  = 32'h0000_0010;
    step_valid_a = 1'b1;
    #1;
    checkOutput("bp_tready", {31'b0, load_ready_a}, 32'h0);
    applyStimulus("bp_hold_0", 32'h1234_5778);
    step_valid_a = 1'b0;
    applyStimulus("bp_hold_1", 32'h1234_5778);
    applyStimulus("bp_hold_2", 32'h1234_5778);
    load_valid_a = 1'b0;
    out_ready_a  = 1'b1;
    applyStimulus("bp_rel_0", 32'h1234_5788);
    applyStimulus("bp_rel_1", 32'h1234_5798);

    // Load and step update together; half-scale step toggles the MSB
    load_data_a  = 32'h0;
    load_valid_a = 1'b1;
    step_data_a  = 32'h8000_0000;
    step_valid_a = 1'b1;
    applyStimulus("both_load", 32'h0);
    load_valid_a = 1'b0;
    step_valid_a = 1'b0;
    applyStimulus("msb_0", 32'h8000_0000);
    applyStimulus("msb_1", 32'h0000_0000);

    // Step of zero holds the phase
    step_data_a  = 32'h0;
    step_valid_a = 1'b1;
    applyStimulus("zero_step_0", 32'h8000_0000);
    step_valid_a = 1'b0;
    applyStimulus("zero_step_1", 32'h8000_0000);
    applyStimulus("zero_step_2", 32'h8000_0000);

    // Instance B: run, then reset mid-stream with a competing load and step
    rst_b       = 1'b0;
    out_ready_b = 1'b1;
    applyStimulusB("b_run_0", 32'h0000_1010);
    applyStimulusB("b_run_1", 32'h0000_1020);
    applyStimulusB("b_run_2", 32'h0000_1030);
    rst_b        = 1'b1;
    load_data_b  = 32'h0000_ABCD;
    load_valid_b = 1'b1;
    step_data_b  = 32'h0000_0055;
    step_valid_b = 1'b1;
    applyStimulusB("b_reset", 32'h0000_1000);
    checkOutput("b_reset_tvalid", {31'b0, out_valid_b}, 32'h1);
    rst_b        = 1'b0;
    load_valid_b = 1'b0;
    step_valid_b = 1'b0;
    applyStimulusB("b_after_0", 32'h0000_1010);
    applyStimulusB("b_after_1", 32'h0000_1020);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
